// File: rtl/pixel_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo_writer
// Purpose  : Frames a valid/ready pixel stream into the image-writer FIFO,
//            checking geometry. Optional macro: PIXEL_FIFO_WRITER_FRAME_TAG_EN
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo_writer #(
  parameter int DWIDTH = 24,
  parameter int CNT_W  = 22
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [10:0]       width,
  input  logic [10:0]       height,
  input  logic [10:0]       num_frame,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              fifo_wrreq,
  output logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_full,
  input  logic              fifo_afull,
  output logic [15:0]       frame_cnt,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic              err_long,
  output logic              err_ovf
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACTIVE   = 3'd1,
    DISCARD  = 3'd2,
    DONE     = 3'd3
`ifdef PIXEL_FIFO_WRITER_FRAME_TAG_EN
    , TAG_WAIT = 3'd4
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  pix_cnt, pix_cnt_nxt;
  logic [CNT_W-1:0]  total, total_nxt;
  logic [CNT_W-1:0]  geom_total;
  logic [CNT_W-1:0]  cnt_new;
  logic [CNT_W-1:0]  len;
  logic [15:0]       frame_cnt_nxt;
  logic [DWIDTH-1:0] data_nxt;
  logic              wr_nxt;
  logic              short_set;
  logic              long_set;
  logic              accept;
  logic              take;
`ifdef PIXEL_FIFO_WRITER_FRAME_TAG_EN
  logic [DWIDTH-1:0] tag_word;
`endif

  assign geom_total = CNT_W'(width) * CNT_W'(height);
  assign busy       = (state == ACTIVE) || (state == DISCARD);
  assign done       = (state == DONE);

  always_comb begin
    in_ready = 1'b1;
    case (state)
      ACTIVE:  in_ready = !fifo_afull;
`ifdef PIXEL_FIFO_WRITER_FRAME_TAG_EN
      // The sof pixel is held off until its tag word has been written.
      IDLE:    in_ready = !(in_valid && in_sof);
`endif
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    pix_cnt_nxt   = pix_cnt;
    total_nxt     = total;
    frame_cnt_nxt = frame_cnt;
    wr_nxt        = 1'b0;
    data_nxt      = fifo_data;
    short_set     = 1'b0;
    long_set      = 1'b0;
    take          = 1'b0;
    accept        = in_valid && in_ready;
    cnt_new       = in_sof ? CNT_W'(1) : pix_cnt + CNT_W'(1);
    len           = (state == ACTIVE) ? total : geom_total;
`ifdef PIXEL_FIFO_WRITER_FRAME_TAG_EN
    tag_word                = '0;
    tag_word[DWIDTH-1 -: 8] = 8'hA5;
    tag_word[15:0]          = frame_cnt;
`endif

    case (state)
      IDLE: begin
`ifdef PIXEL_FIFO_WRITER_FRAME_TAG_EN
        if (in_valid && in_sof && !fifo_afull) begin
          wr_nxt    = 1'b1;
          data_nxt  = tag_word;
          state_nxt = TAG_WAIT;
        end
`else
        take = accept && in_sof;
`endif
      end
`ifdef PIXEL_FIFO_WRITER_FRAME_TAG_EN
      TAG_WAIT: take = accept && in_sof;
`endif
      ACTIVE:  take = accept;
      DISCARD: if (accept && in_eof) state_nxt = IDLE;
      default: ;
    endcase

    // Every pixel that belongs to a frame is written, including the one
    // that overruns the geometry; the count decides where the frame goes next.
    if (take) begin
      wr_nxt      = 1'b1;
      data_nxt    = in_data;
      pix_cnt_nxt = cnt_new;
      total_nxt   = len;
      state_nxt   = ACTIVE;
      if (in_sof && (state == ACTIVE))
        short_set = 1'b1;
      if (len == '0) begin
        long_set  = 1'b1;
        state_nxt = DISCARD;
      end else if (in_eof) begin
        if (cnt_new < len) begin
          short_set = 1'b1;
          state_nxt = IDLE;
        end else begin
          frame_cnt_nxt = frame_cnt + 16'd1;
          state_nxt     = ((num_frame != 11'd0) &&
                           (frame_cnt_nxt == {5'd0, num_frame})) ? DONE : IDLE;
        end
      end else if (cnt_new == len) begin
        long_set  = 1'b1;
        state_nxt = DISCARD;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      total      <= '0;
      frame_cnt  <= '0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pix_cnt    <= pix_cnt_nxt;
      total      <= total_nxt;
      frame_cnt  <= frame_cnt_nxt;
      fifo_wrreq <= wr_nxt;
      fifo_data  <= data_nxt;
      err_short  <= err_short | short_set;
      err_long   <= err_long | long_set;
      err_ovf    <= err_ovf | (fifo_wrreq & fifo_full);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_fifo_writer.sv
`default_nettype none
// Randomized bench for pixel_fifo_writer against a frame-level reference model.
module tb_pixel_fifo_writer;
  localparam int DW = 24;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [10:0]   width = 11'd4, height = 11'd2, num_frame = 11'd2;
  logic          in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          fifo_full = 1'b0, fifo_afull = 1'b0;
  logic          in_ready, fifo_wrreq, busy, done, err_short, err_long, err_ovf;
  logic [DW-1:0] fifo_data;
  logic [15:0]   frame_cnt;

  pixel_fifo_writer #(.DWIDTH(DW), .CNT_W(22)) dut (
    .clock(clock), .reset_n(reset_n), .width(width), .height(height),
    .num_frame(num_frame), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_full(fifo_full),
    .fifo_afull(fifo_afull), .frame_cnt(frame_cnt), .busy(busy), .done(done),
    .err_short(err_short), .err_long(err_long), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  bit rnd_en   = 1'b0;

  // Reference model: frame membership flags plus the pixel count of the frame.
  bit            m_active, m_discard, m_done, m_short, m_long, m_ovf, m_wr;
  int            m_cnt, m_total, m_frames;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 0; m_discard = 0; m_done = 0; m_short = 0; m_long = 0; m_ovf = 0;
    m_wr = 0; m_cnt = 0; m_total = 0; m_frames = 0; m_data = '0;
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input bit s, input bit e);
    if (m_done) return;
    if (m_discard) begin
      if (e) m_discard = 0;
      return;
    end
    if (!m_active && !s) return;
    if (s) begin
      if (m_active) m_short = 1;
      m_cnt   = 0;
      m_total = int'(width) * int'(height);
    end
    m_cnt++;
    m_wr     = 1;
    m_data   = d;
    m_active = 1;
    if (m_total == 0) begin
      m_long = 1; m_active = 0; m_discard = 1;
    end else if (e) begin
      m_active = 0;
      if (m_cnt < m_total) m_short = 1;
      else begin
        m_frames++;
        if (num_frame != 0 && m_frames == int'(num_frame)) m_done = 1;
      end
    end else if (m_cnt == m_total) begin
      m_long = 1; m_active = 0; m_discard = 1;
    end
  endtask

  task automatic check_outputs();
    check("fifo_wrreq", 32'(fifo_wrreq), 32'(m_wr));
    check("fifo_data",  32'(fifo_data),  32'(m_data));
    check("frame_cnt",  32'(frame_cnt),  32'(m_frames & 16'hFFFF));
    check("busy",       32'(busy),       32'(m_active | m_discard));
    check("done",       32'(done),       32'(m_done));
    check("err_short",  32'(err_short),  32'(m_short));
    check("err_long",   32'(err_long),   32'(m_long));
    check("err_ovf",    32'(err_ovf),    32'(m_ovf));
  endtask

  // One clock: drive at edge+1, predict the transfer, compare after the edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit s, input bit e,
                      input bit a, input bit f, output bit acc);
    bit exp_ready, ovf_n;
    in_valid = v; in_data = d; in_sof = s; in_eof = e; fifo_afull = a; fifo_full = f;
    #1;
    exp_ready = !(m_active && a);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc   = v && exp_ready;
    ovf_n = m_ovf || (m_wr && f);
    m_wr  = 0;
    if (acc) model_accept(d, s, e);
    m_ovf = ovf_n;
    @(posedge clock); #1;
    if (fifo_wrreq) n_writes++;
    check_outputs();
  endtask

  task automatic send_pixel(input logic [DW-1:0] d, input bit s, input bit e);
    bit acc = 0;
    if (rnd_en)
      repeat ($urandom_range(0, 2))
        step(1'b0, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'b0, acc);
    for (int t = 0; t < 64; t++) begin
      step(1'b1, d, s, e, rnd_en && ($urandom_range(0, 5) == 0), 1'b0, acc);
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int n, input int base, input int eof_at);
    for (int i = 1; i <= n; i++)
      send_pixel(DW'(base + i - 1), i == 1, i == eof_at);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_outputs();
    in_valid = 1'b0; fifo_full = 1'b0; fifo_afull = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    n_writes = 0;
  endtask

  initial begin
    bit acc;
    int tot, n, eof_at;
    model_reset();
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_outputs();
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Two clean 4x2 frames, num_frame=2.
    send_frame(8, 1, 8);
    send_frame(8, 9, 8);
    step(1'b1, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    check("clean_writes", 32'(n_writes), 32'd16);
    check("clean_frames", 32'(frame_cnt), 32'd2);
    check("clean_done",   32'(done), 32'd1);

    // Short frame, then a normal one.
    num_frame = 11'd0;
    do_reset();
    send_frame(5, 1, 5);
    check("short_err", 32'(err_short), 32'd1);
    check("short_writes", 32'(n_writes), 32'd5);
    send_frame(8, 100, 8);
    check("after_short_frames", 32'(frame_cnt), 32'd1);

    // Long frame: ten pixels, eof on the tenth.
    do_reset();
    send_frame(10, 200, 10);
    check("long_err", 32'(err_long), 32'd1);
    check("long_writes", 32'(n_writes), 32'd8);
    check("long_idle", 32'(busy), 32'd0);

    // Almost-full back-pressure for five cycles mid-frame.
    do_reset();
    send_frame(3, 300, 0);
    repeat (5) begin
      step(1'b1, 24'd303, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      check("afull_stall", 32'(acc), 32'd0);
    end
    for (int i = 4; i <= 8; i++) send_pixel(DW'(299 + i), 1'b0, i == 8);
    check("afull_writes", 32'(n_writes), 32'd8);
    check("afull_frames", 32'(frame_cnt), 32'd1);

    // Overflow: fifo_full while a write is being presented.
    do_reset();
    send_frame(2, 400, 0);
    step(1'b1, 24'd402, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 4; i <= 8; i++) send_pixel(DW'(399 + i), 1'b0, i == 8);
    check("ovf_sticky", 32'(err_ovf), 32'd1);

    // Reset in the middle of a frame, then a full frame from scratch.
    do_reset();
    send_frame(3, 500, 0);
    do_reset();
    send_frame(8, 600, 8);
    check("post_rst_frames", 32'(frame_cnt), 32'd1);
    check("post_rst_short", 32'(err_short), 32'd0);

    // Randomized traffic over small geometries.
    rnd_en = 1'b1;
    for (int it = 0; it < 160; it++) begin
      if (!(m_active || m_discard)) begin
        if ($urandom_range(0, 4) == 0) begin
          width  = 11'($urandom_range(0, 4));
          height = 11'($urandom_range(0, 3));
          if ($urandom_range(0, 8) == 0) width = 11'd0;
        end
        if ($urandom_range(0, 10) == 0) num_frame = 11'($urandom_range(0, 4));
      end
      if (m_done && $urandom_range(0, 2) == 0) do_reset();
      tot = int'(width) * int'(height);
      n   = tot + $urandom_range(0, 4) - 2;
      if (n < 1) n = 1;
      eof_at = ($urandom_range(0, 5) == 0) ? 0 : n;
      if ($urandom_range(0, 7) == 0) send_pixel(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) send_frame(2, it * 16, 0);
      send_frame(n, it * 16 + 1000, eof_at);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_fifo_writer.md
Name: pixel_fifo_writer

Overview:
- Stage directly upstream of the testbench image writer.
- Accepts a valid/ready pixel stream with start-of-frame and end-of-frame markers from the processing core, and writes accepted pixels into the output FIFO that the image writer drains.
- Checks frame geometry against width*height, drops malformed or excess traffic, counts frames, and stops after num_frame frames.

Parameters:
- DWIDTH, 24, pixel word width; packed RGB as {R[23:16], G[15:8], B[7:0]}.
- CNT_W, 22, pixel counter width; must be at least 22 to hold 2047*2047.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- width  in  11  pixels per line; static while busy=1.
- height  in  11  lines per frame; static while busy=1.
- num_frame  in  11  frames to pass; 0 = unlimited.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept; transfer when in_valid&&in_ready.
- in_data  in  DWIDTH  input pixel.
- in_sof  in  1  marks first pixel of frame.
- in_eof  in  1  marks last pixel of frame.
- fifo_wrreq  out  1  registered FIFO write strobe.
- fifo_data  out  DWIDTH  registered FIFO write data.
- fifo_full  in  1  FIFO full.
- fifo_afull  in  1  FIFO almost-full (asserted when 2 or fewer words free).
- frame_cnt  out  16  completed good frames.
- busy  out  1  state is ACTIVE or DISCARD.
- done  out  1  num_frame frames completed.
- err_short  out  1  sticky: frame ended early (eof or new sof before width*height pixels).
- err_long  out  1  sticky: width*height reached without eof.
- err_ovf  out  1  sticky: fifo_wrreq asserted while fifo_full=1.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs are 0 except in_ready: fifo_wrreq=0, fifo_data=0, frame_cnt=0, busy=0, done=0, all err_*=0, pixel counter=0.
- Reset mid-frame aborts the frame with no flush.
- Frame size: total = width*height, computed unsigned at CNT_W bits and registered when entering ACTIVE.
- Write path latency: 1 cycle.
  - An accepted pixel that is to be written sets fifo_wrreq=1 and fifo_data=in_data on the next edge.
  - Otherwise fifo_wrreq=0 and fifo_data holds its value.
- in_ready:
  - IDLE: 1.
  - ACTIVE: !fifo_afull.
  - DISCARD: 1.
  - DONE: 1.
- States:
  - IDLE: pixels without sof are dropped. Accepted sof pixel: write it, pix_cnt=1, go ACTIVE. If total==1 and eof is also set: frame complete, stay IDLE.
  - ACTIVE, accepted pixel:
    - Pixel with sof: err_short=1; pixel restarts a new frame (write it, pix_cnt=1).
    - Otherwise write it and pix_cnt++.
    - If the pixel has eof and pix_cnt+1 < total: err_short=1, go IDLE, frame_cnt unchanged.
    - If the pixel has eof and pix_cnt+1 == total: frame_cnt++, go IDLE, or go DONE if num_frame!=0 and frame_cnt+1==num_frame.
    - If the pixel has no eof and pix_cnt+1 == total: err_long=1, go DISCARD; the pixel is still written and frame_cnt is unchanged.
  - DISCARD: drop all pixels until an accepted pixel with eof, then go IDLE. A sof in DISCARD is dropped; the block resyncs on the next sof.
  - DONE: drop everything. Leave only by reset.
- frame_cnt wraps at 0xFFFF.
- done=1 exactly while in DONE.
- sof and eof on the same pixel counts as a 1-pixel frame.
- width==0 or height==0: total=0. Every sof pixel is written, then err_long=1 and the block goes to DISCARD.
- Overflow: if fifo_wrreq=1 while fifo_full=1, set err_ovf=1; the data is still presented (FIFO drops it).
- in_valid with in_ready=0: no state change; upstream holds its data.

Optional Feature:
- Macro: PIXEL_FIFO_WRITER_FRAME_TAG_EN.
- When defined:
  - In IDLE, when in_valid&&in_sof and !fifo_afull, in_ready=0 for that cycle.
  - The next edge writes the tag word {8'hA5, zero-pad, frame_cnt[15:0]} (DWIDTH bits) and enters TAG_WAIT.
  - TAG_WAIT: in_ready=1; the sof pixel is accepted and handled exactly as the IDLE sof case.
  - One extra FIFO word per started frame; no tag in DISCARD or DONE.
- When not defined: no tag word, no TAG_WAIT state; behaviour as above.

Test Plan:
- width=4, height=2, num_frame=2; two clean 8-pixel frames with data 1..8 and 9..16, fifo never afull:
  - 16 FIFO writes in order, each 1 cycle after acceptance.
  - frame_cnt=2, done=1, no err_*.
- Same setup, eof on pixel 5: err_short=1, 5 writes, frame_cnt=0, next sof frame accepted normally.
- width=4, height=2, 10 pixels with eof on pixel 10: 8 writes, err_long=1, pixels 9-10 dropped, back to IDLE.
- Hold fifo_afull=1 for 5 cycles mid-frame with in_valid=1: in_ready=0 for those cycles, no writes, no data loss; resumes in order.
- Force fifo_full=1 together with a pending fifo_wrreq: err_ovf=1 stays set until reset_n=0.
- Pull reset_n low mid-frame (pixel 3 of 8): all outputs 0 immediately with in_ready=1. Next frame counts from pix_cnt=1. With PIXEL_FIFO_WRITER_FRAME_TAG_EN defined, the first FIFO word is 0xA50000.
